// File: rtl/alarm_sequencer_if.sv
// Signal bundle between the clock/keypad front end and the alarm sequencer.
// The master drives time, alarm settings and key pulses; the slave returns alarm status.
interface alarm_sequencer_if;
   logic       tick_1hz;
   logic [7:0] hour;
   logic [7:0] minute;
   logic [7:0] second;
   logic [7:0] alarm_hour;
   logic [7:0] alarm_minute;
   logic       alarm_en;
   logic       snooze;
   logic       dismiss;
   logic       alert;
   logic [1:0] state;
   logic [1:0] snooze_cnt;

   modport master (
      output tick_1hz, hour, minute, second, alarm_hour, alarm_minute,
             alarm_en, snooze, dismiss,
      input  alert, state, snooze_cnt
   );

   modport slave (
      input  tick_1hz, hour, minute, second, alarm_hour, alarm_minute,
             alarm_en, snooze, dismiss,
      output alert, state, snooze_cnt
   );
endinterface

// File: rtl/alarm_sequencer.sv
// Alarm-clock sequencer: rings on the alarm minute, handles snooze/dismiss and
// auto-snooze/auto-stop timeouts counted in 1 Hz ticks.
module alarm_sequencer #(
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_SEC = 300,
   parameter int MAX_SNOOZE = 3
) (
   input  logic               clk,
   input  logic               reset,
   alarm_sequencer_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RING   = 2'b01,
      SNOOZE = 2'b10,
      UNUSED = 2'b11
   } state_t;

   localparam logic [8:0] RING_T   = 9'(RING_SEC);
   localparam logic [8:0] SNOOZE_T = 9'(SNOOZE_SEC);
   localparam logic [1:0] MAX_CNT  = 2'(MAX_SNOOZE);

   state_t     state_q;
   logic       alert_q;
   logic [1:0] cnt_q;
   logic [8:0] timer_q;
   logic       armed_q;

   logic time_match;
   logic match;
   logic can_snooze;
   logic expiring;
   logic stop;

   assign time_match = (bus.hour == bus.alarm_hour) && (bus.minute == bus.alarm_minute);
   assign match      = bus.tick_1hz && bus.alarm_en && armed_q && time_match &&
                       (bus.second == 8'h00);
   assign can_snooze = (cnt_q < MAX_CNT);
   assign expiring   = bus.tick_1hz && (timer_q == 9'd1);
   // alarm_en low outranks dismiss; both abandon the current event.
   assign stop       = !bus.alarm_en || bus.dismiss;

   // NOTE: all state here updates with non-blocking assignments so every branch
   // reads the pre-edge values; blocking writes would leak between branches.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         alert_q <= 1'b0;
         cnt_q   <= 2'd0;
         timer_q <= 9'd0;
         armed_q <= 1'b1;
      end else begin
         if (!time_match)
            armed_q <= 1'b1;

         unique case (state_q)
            IDLE: begin
               if (match) begin
                  state_q <= RING;
                  alert_q <= 1'b1;
                  timer_q <= RING_T;
                  cnt_q   <= 2'd0;
                  armed_q <= 1'b0;
               end
            end

            RING: begin
               if (stop) begin
                  state_q <= IDLE;
                  alert_q <= 1'b0;
                  timer_q <= 9'd0;
                  cnt_q   <= 2'd0;
               end else if ((bus.snooze || expiring) && can_snooze) begin
                  state_q <= SNOOZE;
                  alert_q <= 1'b0;
                  timer_q <= SNOOZE_T;
                  cnt_q   <= cnt_q + 2'd1;
               end else if (expiring) begin
                  // Snoozes exhausted: the event ends on its own.
                  state_q <= IDLE;
                  alert_q <= 1'b0;
                  timer_q <= 9'd0;
                  cnt_q   <= 2'd0;
               end else if (bus.tick_1hz && timer_q != 9'd0) begin
                  timer_q <= timer_q - 9'd1;
               end
            end

            SNOOZE: begin
               if (stop) begin
                  state_q <= IDLE;
                  alert_q <= 1'b0;
                  timer_q <= 9'd0;
                  cnt_q   <= 2'd0;
               end else if (expiring) begin
                  state_q <= RING;
                  alert_q <= 1'b1;
                  timer_q <= RING_T;
                  armed_q <= 1'b0;
               end else if (bus.tick_1hz && timer_q != 9'd0) begin
                  timer_q <= timer_q - 9'd1;
               end
            end

            default: begin
               state_q <= IDLE;
               alert_q <= 1'b0;
               timer_q <= 9'd0;
               cnt_q   <= 2'd0;
            end
         endcase
      end
   end

   assign bus.alert      = alert_q;
   assign bus.state      = state_q;
   assign bus.snooze_cnt = cnt_q;

endmodule

// File: doc/alarm_sequencer.md
ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 Parameter RING_SEC, default 60: number of 1 Hz ticks the alarm rings before auto-snooze or auto-stop; legal range 1..511.
REQ-002 Parameter SNOOZE_SEC, default 300: number of 1 Hz ticks spent in snooze before re-ringing; legal range 1..511.
REQ-003 Parameter MAX_SNOOZE, default 3: maximum snoozes per alarm event; legal range 0..3.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 tick_1hz  in  1  one-clk-wide pulse, once per second, aligned with the seconds counter update.
REQ-007 hour  in  8  current hour, BCD 00..23.
REQ-008 minute  in  8  current minute, BCD 00..59.
REQ-009 second  in  8  current second, BCD 00..59.
REQ-010 alarm_hour  in  8  stored alarm hour, BCD.
REQ-011 alarm_minute  in  8  stored alarm minute, BCD.
REQ-012 alarm_en  in  1  level; alarm function enabled.
REQ-013 snooze  in  1  one-clk pulse, debounced snooze key.
REQ-014 dismiss  in  1  one-clk pulse, debounced dismiss key.
REQ-015 alert  out  1  registered; high while ringing.
REQ-016 state  out  2  registered FSM state: 00 IDLE, 01 RING, 10 SNOOZE.
REQ-017 snooze_cnt  out  2  registered count of snoozes used in the current event.

Function
REQ-018 Match SHALL be alarm_en and hour==alarm_hour and minute==alarm_minute and second==8'h00, sampled only on cycles with tick_1hz=1.
REQ-019 Internal armed flag SHALL be set whenever minute!=alarm_minute or hour!=alarm_hour, and cleared on entry to RING; match SHALL be qualified by armed (one event per matching minute).
REQ-020 IDLE: on qualified match, next cycle state=RING, alert=1, timer=RING_SEC, snooze_cnt=0.
REQ-021 9-bit timer SHALL decrement by 1 only on tick_1hz in RING or SNOOZE; it SHALL never wrap below 0.
REQ-022 RING + snooze pulse with snooze_cnt<MAX_SNOOZE: next state=SNOOZE, alert=0, timer=SNOOZE_SEC, snooze_cnt+1.
REQ-023 RING + snooze pulse with snooze_cnt==MAX_SNOOZE: ignored; stay in RING, timer continues.
REQ-024 RING timeout (tick while timer==1): if snooze_cnt<MAX_SNOOZE act as a snooze (REQ-022); else go to IDLE, snooze_cnt=0.
REQ-025 SNOOZE timeout (tick while timer==1): next state=RING, alert=1, timer=RING_SEC, snooze_cnt unchanged.
REQ-026 SNOOZE + snooze pulse: ignored.
REQ-027 dismiss in RING or SNOOZE: next state=IDLE, alert=0, timer=0, snooze_cnt=0; dismiss in IDLE: no effect.
REQ-028 Priority on the same cycle: reset > alarm_en=0 > dismiss > snooze > timer tick.
REQ-029 alarm_en falling in RING or SNOOZE: next state=IDLE, alert=0, snooze_cnt=0.
REQ-030 Unused state encoding 11 SHALL transition to IDLE on the next cycle with alert=0.
REQ-031 Latency from qualifying input cycle to output change SHALL be exactly 1 clk.

Reset
REQ-032 On reset: state=IDLE, alert=0, snooze_cnt=0, timer=0, armed=1.
REQ-033 Reset asserted mid-RING or mid-SNOOZE SHALL take effect on the next edge regardless of other inputs; no event is resumed.

Verification
REQ-034 alarm 07:30, time 07:29:59 -> tick to 07:30:00 -> alert=1, state=01 one clk later; further ticks in 07:30 after dismiss -> no re-ring.
REQ-035 RING_SEC=4, SNOOZE_SEC=3: ring, press snooze -> state=10, snooze_cnt=1; 3 ticks -> state=01, alert=1.
REQ-036 MAX_SNOOZE=1: snooze once, re-ring, press snooze -> ignored, alert stays 1; RING_SEC ticks later -> state=00, snooze_cnt=0.
REQ-037 snooze and dismiss pulses same cycle in RING -> state=00, snooze_cnt=0.
REQ-038 alarm_en dropped in SNOOZE -> state=00 next clk; reset pulse in RING -> alert=0, state=00, snooze_cnt=0.
